// File: rtl/char_buffer_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : char_buffer_reader_pkg
// Description : Shared geometry, field widths and FSM encoding for the
//               raster-side character buffer reader.
// Revision    : 1.0
// ============================================================================
package char_buffer_reader_pkg;

    localparam int COLS_DEF   = 80;
    localparam int ROWS_DEF   = 32;
    localparam int CHAR_W     = 8;
    localparam int CHAR_H_DEF = 15;
    localparam int LEAD       = 3;

    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;
    localparam int SCAN_W = 4;
    localparam int PIX_W  = 3;
    localparam int CODE_W = 7;

    localparam logic [CODE_W-1:0] CHAR_NUL = 7'h00;

    typedef enum logic [1:0] {
        ST_VBLANK = 2'd0,
        ST_HBLANK = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/char_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : char_pixel_shifter
// Description : 8-bit glyph row shifter, MSB first, with per-cell inversion.
// Revision    : 1.0
// ============================================================================
module char_pixel_shifter
    import char_buffer_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [CHAR_W-1:0] data,
    input  logic              invert,
    output logic              pixel,
    output logic              valid,
    output logic              last
);

    logic [CHAR_W-1:0] r_sh;
    logic [PIX_W-1:0]  r_cnt;
    logic              r_valid;
    logic              r_inv;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_sh    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_inv   <= 1'b0;
        end else if (load) begin
            r_sh    <= data;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_inv   <= invert;
        end else if (r_valid) begin
            r_sh  <= {r_sh[CHAR_W-2:0], 1'b0};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pixel = r_valid & (r_sh[CHAR_W-1] ^ r_inv);
    assign valid = r_valid;
    assign last  = r_valid & (r_cnt == 3'd7);

endmodule
`default_nettype wire

// File: rtl/char_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : char_buffer_reader
// Description : Fetches char codes and glyph rows per active line and
//               serialises 640 pixels per line. Optional macro:
//               CURSOR_BLINK_EN (cursor shown only when frame_cnt[4]=1).
// Revision    : 1.0
// ============================================================================
module char_buffer_reader
    import char_buffer_reader_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int CHAR_H = CHAR_H_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frameStart,
    input  logic                       lineStart,
    input  logic                       blankScreen,
    input  logic                       cursorEn,
    input  logic [ROW_W-1:0]           cursorRow,
    input  logic [COL_W-1:0]           cursorCol,
    output logic                       charRdEn,
    output logic [COL_W+ROW_W-1:0]     charRdAddr,
    input  logic [CODE_W-1:0]          charRdData,
    output logic [CODE_W+SCAN_W-1:0]   fontRdAddr,
    input  logic [CHAR_W-1:0]          fontRdData,
    output logic                       pixelOut,
    output logic                       pixelValid,
    output logic                       lineDone
);

    localparam logic [COL_W-1:0]  c_last_col  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  c_last_row  = ROW_W'(ROWS - 1);
    localparam logic [SCAN_W-1:0] c_last_scan = SCAN_W'(CHAR_H - 1);

    state_t                     r_state, w_state_nx;
    logic [COL_W-1:0]           r_col;
    logic [PIX_W-1:0]           r_pix;
    logic [SCAN_W-1:0]          r_scan;
    logic [ROW_W-1:0]           r_row;
    logic                       r_rd_en;
    logic [COL_W+ROW_W-1:0]     r_rd_addr;
    logic                       r_fetch_d1, r_fetch_d2;
    logic                       r_hit0, r_hit1, r_hit2;
    logic                       r_line_done;
    logic [CODE_W+SCAN_W-1:0]   r_font_addr;

    logic                       w_start, w_issue, w_fetch, w_last_fetch;
    logic [COL_W-1:0]           w_next_col;
    logic                       w_cursor_on, w_hit;
    logic                       w_sh_pixel, w_sh_valid, w_sh_last;
    logic                       w_drain_end, w_frame_end;

`ifdef CURSOR_BLINK_EN
    logic [4:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (frameStart) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end

    assign w_cursor_on = cursorEn & r_frame_cnt[4];
`else
    assign w_cursor_on = cursorEn;
`endif

    assign w_start      = (r_state == ST_HBLANK) & lineStart;
    assign w_issue      = (r_state == ST_ACTIVE) & (r_pix == 3'd7);
    assign w_fetch      = w_start | w_issue;
    assign w_next_col   = w_start ? '0 : r_col + 7'd1;
    assign w_last_fetch = w_fetch & (w_next_col == c_last_col);
    assign w_hit        = w_cursor_on & (w_next_col == cursorCol) & (r_row == cursorRow);
    assign w_frame_end  = (r_scan == c_last_scan) & (r_row == c_last_row);

    // The line ends once the final cell's last pixel is out and no glyph load is still in flight.
    assign w_drain_end  = (r_state == ST_DRAIN) & ~r_rd_en & ~r_fetch_d1 & ~r_fetch_d2 & w_sh_last;

    always_comb begin
        w_state_nx = r_state;
        if (frameStart) begin
            w_state_nx = ST_HBLANK;
        end else begin
            case (r_state)
                ST_VBLANK: w_state_nx = ST_VBLANK;
                ST_HBLANK: if (lineStart)    w_state_nx = w_last_fetch ? ST_DRAIN : ST_ACTIVE;
                ST_ACTIVE: if (w_last_fetch) w_state_nx = ST_DRAIN;
                ST_DRAIN:  if (w_drain_end)  w_state_nx = w_frame_end ? ST_VBLANK : ST_HBLANK;
                default:   w_state_nx = ST_VBLANK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_VBLANK;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col       <= '0;
            r_pix       <= '0;
            r_scan      <= '0;
            r_row       <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_fetch_d1  <= 1'b0;
            r_fetch_d2  <= 1'b0;
            r_hit0      <= 1'b0;
            r_hit1      <= 1'b0;
            r_hit2      <= 1'b0;
            r_line_done <= 1'b0;
        end else if (frameStart) begin
            r_col       <= '0;
            r_pix       <= '0;
            r_scan      <= '0;
            r_row       <= '0;
            r_rd_en     <= 1'b0;
            r_fetch_d1  <= 1'b0;
            r_fetch_d2  <= 1'b0;
            r_hit0      <= 1'b0;
            r_hit1      <= 1'b0;
            r_hit2      <= 1'b0;
            r_line_done <= 1'b0;
        end else begin
            r_rd_en     <= w_fetch;
            r_fetch_d1  <= r_rd_en;
            r_fetch_d2  <= r_fetch_d1;
            r_hit1      <= r_hit0;
            r_hit2      <= r_hit1;
            r_line_done <= w_drain_end;
            if (w_fetch) begin
                r_col     <= w_next_col;
                r_pix     <= '0;
                r_rd_addr <= {w_next_col, r_row};
                r_hit0    <= w_hit;
            end else if (r_state == ST_ACTIVE) begin
                r_pix <= r_pix + 3'd1;
            end
            if (w_drain_end) begin
                if (r_scan == c_last_scan) begin
                    r_scan <= '0;
                    r_row  <= (r_row == c_last_row) ? '0 : r_row + 5'd1;
                end else begin
                    r_scan <= r_scan + 4'd1;
                end
            end
        end
    end

    // Font address is formed from the code the cycle it returns, then held while idle.
    assign fontRdAddr = r_fetch_d1 ? {charRdData, r_scan} : r_font_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_font_addr <= {CHAR_NUL, 4'd0};
        end else begin
            r_font_addr <= fontRdAddr;
        end
    end

    char_pixel_shifter u_shifter (
        .clk    (clk),
        .reset  (reset),
        .clear  (frameStart),
        .load   (r_fetch_d2),
        .data   (fontRdData),
        .invert (r_hit2),
        .pixel  (w_sh_pixel),
        .valid  (w_sh_valid),
        .last   (w_sh_last)
    );

    assign charRdEn   = r_rd_en;
    assign charRdAddr = r_rd_addr;
    assign pixelOut   = w_sh_pixel & ~blankScreen;
    assign pixelValid = w_sh_valid;
    assign lineDone   = r_line_done;

endmodule
`default_nettype wire

// File: tb/tb_char_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_buffer_reader
// Description : Scoreboard bench for char_buffer_reader with buffer/ROM models.
// Revision    : 1.0
// ============================================================================
module tb_char_buffer_reader;
    import char_buffer_reader_pkg::*;

    logic        clk = 1'b0;
    logic        reset, frameStart, lineStart, blankScreen, cursorEn;
    logic [4:0]  cursorRow;
    logic [6:0]  cursorCol;
    logic        charRdEn;
    logic [11:0] charRdAddr;
    logic [6:0]  charRdData = '0;
    logic [10:0] fontRdAddr;
    logic [7:0]  fontRdData = '0;
    logic        pixelOut, pixelValid, lineDone;

    char_buffer_reader dut (
        .clk(clk), .reset(reset), .frameStart(frameStart), .lineStart(lineStart),
        .blankScreen(blankScreen), .cursorEn(cursorEn), .cursorRow(cursorRow),
        .cursorCol(cursorCol), .charRdEn(charRdEn), .charRdAddr(charRdAddr),
        .charRdData(charRdData), .fontRdAddr(fontRdAddr), .fontRdData(fontRdData),
        .pixelOut(pixelOut), .pixelValid(pixelValid), .lineDone(lineDone)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic        exp_pix[$];
    logic [11:0] exp_addr[$];
    logic [6:0]  bufm [0:4095];
    logic        font_fixed_en = 1'b1;
    logic [7:0]  font_fixed = 8'h00;
    logic [4:0]  m_row = '0;
    logic [3:0]  m_scan = '0;
    logic [3:0]  cur_scan = '0;
    int          n_frames = 0;
    int          pv_cnt = 0, rd_cnt = 0, ld_cnt = 0;
    logic        mon_en = 1'b0;
    logic        tb_rd_d1 = 1'b0;

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        if (font_fixed_en) return font_fixed;
        return a[7:0] ^ {a[3:0], a[10:7]};
    endfunction

    function automatic bit cursor_vis();
`ifdef CURSOR_BLINK_EN
        return cursorEn && n_frames[4];
`else
        return cursorEn;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Buffer and font ROM: registered reads, one cycle latency.
    always @(posedge clk) begin
        if (charRdEn) charRdData <= bufm[charRdAddr];
        fontRdData <= font_fn(fontRdAddr);
        tb_rd_d1   <= charRdEn && !frameStart && !reset;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (pixelValid) begin
                pv_cnt++;
                chk("pix_queue_nonempty", 32'(exp_pix.size() != 0), 32'd1);
                if (exp_pix.size() != 0) chk($sformatf("pix%0d", pv_cnt - 1), 32'(pixelOut), 32'(exp_pix.pop_front()));
            end else begin
                chk("pix_zero_when_invalid", 32'(pixelOut), 32'd0);
            end
            if (charRdEn) begin
                rd_cnt++;
                chk("addr_queue_nonempty", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) chk("rd_addr", 32'(charRdAddr), 32'(exp_addr.pop_front()));
            end
            if (tb_rd_d1) chk("font_addr", 32'(fontRdAddr), 32'({charRdData, cur_scan}));
            if (lineDone) ld_cnt++;
        end
    end

    task automatic push_line(input bit blank);
        logic [11:0] a;
        logic [7:0]  g;
        logic        inv;
        for (int k = 0; k < 80; k++) begin
            a = {7'(k), m_row};
            exp_addr.push_back(a);
            g   = font_fn({bufm[a], m_scan});
            inv = cursor_vis() && (7'(k) == cursorCol) && (m_row == cursorRow);
            for (int b = 7; b >= 0; b--) exp_pix.push_back((g[b] ^ inv) & ~blank);
        end
        cur_scan = m_scan;
        pv_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic pulse_line_start();
        @(posedge clk); #1 lineStart = 1'b1;
        @(posedge clk); #1 lineStart = 1'b0;
    endtask

    task automatic frame_pulse();
        @(posedge clk); #1 frameStart = 1'b1;
        @(posedge clk); #1 frameStart = 1'b0;
        n_frames++;
        m_row  = '0;
        m_scan = '0;
    endtask

    task automatic flush();
        exp_pix.delete();
        exp_addr.delete();
    endtask

    task automatic run_line(input bit inject_ls, input bit blank);
        int         n;
        logic [4:0] rr;
        rr = m_row;
        blankScreen = blank;
        push_line(blank);
        pulse_line_start();
        n = 0;
        while (!pixelValid && n < 10) begin @(posedge clk); #1; n++; end
        chk("lead", 32'(n), LEAD);
        n = 0;
        while (!lineDone && n < 800) begin
            @(posedge clk); #1;
            n++;
            lineStart = (inject_ls && n == 100);
        end
        lineStart = 1'b0;
        chk("line_done_seen", 32'(lineDone), 32'd1);
        chk("pv_at_done", 32'(pixelValid), 32'd0);
        chk("pixel_count", 32'(pv_cnt), 32'd640);
        chk("fetch_count", 32'(rd_cnt), 32'd80);
        chk("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
        chk("addr_hold", 32'(charRdAddr), 32'({7'd79, rr}));
        chk("font_hold", 32'(fontRdAddr), 32'({bufm[{7'd79, rr}], m_scan}));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(lineDone), 32'd0);
        blankScreen = 1'b0;
        flush();
        if (m_scan == 4'd14) begin
            m_scan = '0;
            m_row  = (m_row == 5'd31) ? 5'd0 : m_row + 5'd1;
        end else begin
            m_scan = m_scan + 4'd1;
        end
    endtask

    initial begin
        int ld0;
        int targets[5] = '{15, 16, 31, 32, 48};
        reset = 1'b1; frameStart = 1'b0; lineStart = 1'b0; blankScreen = 1'b0;
        cursorEn = 1'b0; cursorRow = '0; cursorCol = '0;
        for (int a = 0; a < 4096; a++) bufm[a] = 7'h41;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pixelOut", 32'(pixelOut), 32'd0);
        chk("rst_pixelValid", 32'(pixelValid), 32'd0);
        chk("rst_lineDone", 32'(lineDone), 32'd0);
        chk("rst_charRdEn", 32'(charRdEn), 32'd0);
        chk("rst_charRdAddr", 32'(charRdAddr), 32'd0);
        chk("rst_fontRdAddr", 32'(fontRdAddr), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Constant glyph 0xA5 across a line of 0x41
        font_fixed_en = 1'b1; font_fixed = 8'hA5;
        frame_pulse();
        run_line(1'b0, 1'b0);

        // Blanked line of solid glyphs, with a stray lineStart mid-line
        font_fixed = 8'hFF;
        run_line(1'b1, 1'b1);

        // Abort at pixel 300 with frameStart
        for (int a = 0; a < 4096; a++) bufm[a] = 7'(a[6:0] ^ a[11:5]);
        font_fixed_en = 1'b0;
        ld0 = ld_cnt;
        push_line(1'b0);
        pulse_line_start();
        repeat (303) @(posedge clk);
        #1 frameStart = 1'b1;
        @(posedge clk); #1 frameStart = 1'b0;
        n_frames++; m_row = '0; m_scan = '0;
        chk("abort_pv_drop", 32'(pixelValid), 32'd0);
        chk("abort_pixel_count", 32'(pv_cnt), 32'd301);
        flush();
        repeat (20) @(posedge clk);
        #1 chk("abort_no_line_done", 32'(ld_cnt), 32'(ld0));
        run_line(1'b0, 1'b0);

        // Cursor at cell (0,0) on a blank glyph across selected frame counts
        font_fixed_en = 1'b1; font_fixed = 8'h00;
        cursorEn = 1'b1; cursorRow = 5'd0; cursorCol = 7'd0;
        for (int t = 0; t < 5; t++) begin
            while (n_frames < targets[t]) frame_pulse();
            run_line(1'b0, 1'b0);
        end

        // Address/scan sweep from frame start through row 3, cursor on the last cell of row 3
        font_fixed_en = 1'b0;
        cursorRow = 5'd3; cursorCol = 7'd79;
        frame_pulse();
        for (int ln = 0; ln < 47; ln++) begin
            font_fixed_en = (ln >= 45);
            run_line(1'b0, 1'b0);
        end
        chk("sweep_row", 32'(m_row), 32'd3);

        // Reset in the middle of a line
        font_fixed_en = 1'b0;
        ld0 = ld_cnt;
        push_line(1'b0);
        pulse_line_start();
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_pixelValid", 32'(pixelValid), 32'd0);
        chk("midrst_charRdEn", 32'(charRdEn), 32'd0);
        chk("midrst_charRdAddr", 32'(charRdAddr), 32'd0);
        chk("midrst_fontRdAddr", 32'(fontRdAddr), 32'd0);
        reset = 1'b0;
        flush();
        n_frames = 0; m_row = '0; m_scan = '0;
        repeat (20) @(posedge clk);
        #1 chk("midrst_no_line_done", 32'(ld_cnt), 32'(ld0));

        // lineStart in VBLANK must not start a line
        pv_cnt = 0; rd_cnt = 0;
        pulse_line_start();
        repeat (12) @(posedge clk);
        #1;
        chk("vblank_no_pixels", 32'(pv_cnt), 32'd0);
        chk("vblank_no_fetch", 32'(rd_cnt), 32'd0);
        frame_pulse();
        run_line(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
